hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32IM core.
- Drives enable/clear of the fetch, decode, execute and memory pipeline registers.
- Generates EX-stage forwarding selects.
- Sequences the iterative M-extension divider: holds the execute stage for a fixed number of cycles while a DIV/DIVU/REM/REMU is in EX, and injects bubbles into MEM.

Parameters:
- DIV_CYCLES, 32, number of BUSY cycles the iterative divider needs (legal range 1..63).
- CNT_W, 6, counter width; must satisfy 2**CNT_W > DIV_CYCLES.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- Rs1D  in  5  decode-stage source register 1
- Rs2D  in  5  decode-stage source register 2
- Rs1E  in  5  execute-stage source register 1
- Rs2E  in  5  execute-stage source register 2
- RdE  in  5  execute-stage destination
- RdM  in  5  memory-stage destination
- RdW  in  5  writeback-stage destination
- RegWriteM  in  1  memory-stage write enable
- RegWriteW  in  1  writeback-stage write enable
- LoadE  in  1  EX instruction is a load (ResultSrcE == memory)
- PCSrcE  in  1  taken branch or jump resolved in EX
- MdDivE  in  1  EX instruction is a divide/remainder op
- StallF  out  1  hold PC register
- StallD  out  1  hold decode register
- FlushD  out  1  clear decode register
- StallE  out  1  hold execute register (drive its en = ~StallE)
- FlushE  out  1  clear execute register
- FlushM  out  1  clear memory register
- ForwardAE  out  2  operand A select: 00 RF, 01 W result, 10 M ALU result
- ForwardBE  out  2  operand B select, same encoding
- md_start  out  1  one-cycle pulse; divider latches forwarded operands
- md_busy  out  1  divider sequence in progress

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE, counter to 0.
  - All outputs are 0 while reset is asserted. Reset mid-division abandons the operation with no residual stall.
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM && RdM != 0 && RdM == Rs1E.
  - Otherwise 01 if RegWriteW && RdW != 0 && RdW == Rs1E.
  - Otherwise 00.
  - ForwardBE uses the same rule with Rs2E.
  - M has priority over W.
- Load-use:
  - lwStall = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
  - lwStall sets StallF = StallD = 1 and FlushE = 1.
- Control hazard: PCSrcE sets FlushD = 1 and FlushE = 1.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE: if MdDivE, assert md_start (combinational), load cnt = DIV_CYCLES-1, and go to BUSY next cycle.
  - BUSY: decrement cnt each cycle. When cnt == 0, go to DONE.
  - DONE: go to IDLE unconditionally. The result is valid and the instruction advances to MEM at the end of this cycle.
  - mdStall = (IDLE && MdDivE) || BUSY.
  - md_busy = BUSY || DONE.
  - Total EX residency of a divide = DIV_CYCLES + 2 cycles.
- mdStall effect:
  - StallF = StallD = StallE = 1.
  - FlushM = 1, so a bubble enters MEM each stalled cycle.
  - FlushE = 0: the stalled divide must never be cleared.
  - Load-use detection is masked. A load-use on the instruction in D is re-detected after the divide leaves.
- DONE cycle:
  - No stall from the FSM. FlushM = 0.
  - Load-use and PCSrcE are evaluated normally.
- Back-to-back divides: the second divide reaches EX the cycle after DONE. The FSM is in IDLE and restarts.
- Simultaneous PCSrcE && MdDivE cannot occur (a divide is never a branch). The bench asserts against it. If both are seen, PCSrcE flushes take effect and the FSM still starts.
- Forwarding selects stay live during the stall. The divider consumes operands only on md_start.
- Outputs are combinational from state and inputs. Only state and cnt are registered.

Decomposition:
- The shared package gains:
  - typedef fwd_sel_e (FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10).
  - typedef md_state_e (MD_IDLE, MD_BUSY, MD_DONE).
  - constant DIV_CYCLES_DEFAULT = 32.
- One natural sub-module, fwd_unit: pure combinational forwarding for a single operand, instantiated twice.
- The FSM and stall logic stay in hazard_ctrl.

Test Plan:
- add x5 in M (RegWriteM=1, RdM=5) and in W (RdW=5), Rs1E=5 -> ForwardAE = 10. Same with RdM=0 -> ForwardAE = 01. RdW=0 as well -> 00.
- LoadE=1, RdE=7, Rs2D=7 -> StallF = StallD = FlushE = 1 for exactly one cycle. With RdE=0 -> no stall.
- PCSrcE=1 for one cycle -> FlushD = FlushE = 1 that cycle only; StallF = 0.
- MdDivE=1 held, DIV_CYCLES=4 -> md_start pulses once in cycle 0. StallE = FlushM = 1 for cycles 0–4 and 0 in cycle 5 (DONE). md_busy = 1 for cycles 1–5. FlushE never 1.
- MdDivE with LoadE=1, RdE=Rs1D asserted mid-BUSY -> FlushE stays 0 throughout. Load-use stall appears only after DONE, once the load reaches EX.
- rst_n low at BUSY cnt=2 -> all outputs 0 immediately. After release with MdDivE=0, FSM is in IDLE and no stall occurs.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / divider sequencing controller.
package hazard_ctrl_pkg;

    localparam int unsigned DIV_CYCLES_DEFAULT = 32;
    localparam int unsigned REG_W              = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select for a single source register; MEM wins over WB.
module hazard_ctrl_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_e_i,
    input  logic             reg_write_m_i,
    input  logic [REG_W-1:0] rd_m_i,
    input  logic             reg_write_w_i,
    input  logic [REG_W-1:0] rd_w_i,
    output logic [1:0]       fwd_sel_o
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
            sel = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
            sel = FWD_W;
        end
    end

    assign fwd_sel_o = 2'(sel);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32IM core: forwarding, load-use and branch
// flushes, and the hold/bubble sequencing of the iterative divider in EX.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MdDivE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             StallE,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             md_start,
    output logic             md_busy
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fwd_a, fwd_b;
    logic             md_stall, lw_stall;

    hazard_ctrl_fwd_unit u_fwd_a (
        .rs_e_i        (Rs1E),
        .reg_write_m_i (RegWriteM),
        .rd_m_i        (RdM),
        .reg_write_w_i (RegWriteW),
        .rd_w_i        (RdW),
        .fwd_sel_o     (fwd_a)
    );

    hazard_ctrl_fwd_unit u_fwd_b (
        .rs_e_i        (Rs2E),
        .reg_write_m_i (RegWriteM),
        .rd_m_i        (RdM),
        .reg_write_w_i (RegWriteW),
        .rd_w_i        (RdW),
        .fwd_sel_o     (fwd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Divider sequence: one IDLE start cycle, DIV_CYCLES BUSY cycles, one DONE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (MdDivE) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // The stalled divide must stay in EX, so load-use detection is masked while it waits.
    always_comb begin
        md_stall  = ((state_q == MD_IDLE) && MdDivE) || (state_q == MD_BUSY);
        lw_stall  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !md_stall;

        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        StallE    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        md_start  = 1'b0;
        md_busy   = 1'b0;

        if (rst_n) begin
            StallF    = lw_stall || md_stall;
            StallD    = lw_stall || md_stall;
            FlushD    = PCSrcE;
            StallE    = md_stall;
            FlushE    = lw_stall || PCSrcE;
            FlushM    = md_stall;
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            md_start  = (state_q == MD_IDLE) && MdDivE;
            md_busy   = (state_q == MD_BUSY) || (state_q == MD_DONE);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with a short divider (DIV_CYCLES = 4).
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       regwm, regww, loade, pcsrce, mddive;
    } in_t;

    typedef struct packed {
        logic       stallf, stalld, flushd, stalle, flushe, flushm;
        logic [1:0] fae, fbe;
        logic       md_start, md_busy;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  e;
        string name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MdDivE;
    logic       StallF, StallD, FlushD, StallE, FlushE, FlushM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       md_start, md_busy;

    int    n_checks = 0;
    int    n_fail   = 0;
    out_t  exp_q[$];
    string nm_q[$];
    vec_t  vecs[$];

    hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MdDivE(MdDivE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .StallE(StallE), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .md_start(md_start), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // A divide is never a branch; stimulus must not drive both.
    always @(negedge clk) begin
        if (rst_n) assert (!(PCSrcE && MdDivE)) else $error("illegal stimulus: PCSrcE with MdDivE");
    end

    function automatic out_t o(input logic sf, sd, fd, se, fe, fm,
                               input logic [1:0] fa, fb, input logic st, bz);
        out_t r;
        r.stallf = sf; r.stalld = sd; r.flushd = fd; r.stalle = se;
        r.flushe = fe; r.flushm = fm; r.fae = fa; r.fbe = fb;
        r.md_start = st; r.md_busy = bz;
        return r;
    endfunction

    function automatic out_t sample();
        return o(StallF, StallD, FlushD, StallE, FlushE, FlushM,
                 ForwardAE, ForwardBE, md_start, md_busy);
    endfunction

    task automatic drive(input in_t i);
        Rs1D = i.rs1d; Rs2D = i.rs2d; Rs1E = i.rs1e; Rs2E = i.rs2e;
        RdE = i.rde; RdM = i.rdm; RdW = i.rdw;
        RegWriteM = i.regwm; RegWriteW = i.regww; LoadE = i.loade;
        PCSrcE = i.pcsrce; MdDivE = i.mddive;
    endtask

    task automatic check_pop();
        out_t  e;
        out_t  a;
        string n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        a = sample();
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %03h (sf sd fd se fe fm fa fb st bz) required %03h", n, a, e);
        end
    endtask

    // One pipeline cycle: inputs change just after the edge, outputs checked mid-cycle.
    task automatic step(input in_t i, input out_t e, input string n);
        @(posedge clk);
        #1;
        drive(i);
        exp_q.push_back(e);
        nm_q.push_back(n);
        @(negedge clk);
        check_pop();
    endtask

    task automatic add_vec(input in_t i, input out_t e, input string n);
        vec_t v;
        v.i = i; v.e = e; v.name = n;
        vecs.push_back(v);
    endtask

    out_t zero_o;
    out_t stall_o;

    initial begin
        in_t t;
        in_t d;

        #200000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t t;
        in_t d;
        zero_o = '0;

        // Reset with live hazards on the inputs: every output must be held low.
        rst_n = 1'b0;
        t = '0; t.regwm = 1; t.rdm = 5; t.rs1e = 5; t.loade = 1; t.rde = 7; t.rs2d = 7;
        t.mddive = 1;
        drive(t);
        #2;
        exp_q.push_back(zero_o); nm_q.push_back("reset_outputs");
        check_pop();
        drive('0);
        @(negedge clk);
        rst_n = 1'b1;

        t = '0; t.regwm = 1; t.rdm = 5; t.regww = 1; t.rdw = 5; t.rs1e = 5;
        add_vec(t, o(0,0,0,0,0,0, 2'b10, 2'b00, 0,0), "fwd_a_m_priority");
        t.rdm = 0;
        add_vec(t, o(0,0,0,0,0,0, 2'b01, 2'b00, 0,0), "fwd_a_w_rdm0");
        t.rdw = 0;
        add_vec(t, o(0,0,0,0,0,0, 2'b00, 2'b00, 0,0), "fwd_a_rf_both0");
        t = '0; t.regwm = 1; t.rdm = 3; t.rs2e = 3; t.regww = 1; t.rdw = 4; t.rs1e = 4;
        add_vec(t, o(0,0,0,0,0,0, 2'b01, 2'b10, 0,0), "fwd_b_m_a_w");
        t = '0; t.rdm = 5; t.rdw = 5; t.rs1e = 5; t.rs2e = 5;
        add_vec(t, o(0,0,0,0,0,0, 2'b00, 2'b00, 0,0), "fwd_no_regwrite");
        t = '0; t.loade = 1; t.rde = 7; t.rs2d = 7;
        add_vec(t, o(1,1,0,0,1,0, 2'b00, 2'b00, 0,0), "loaduse_rs2");
        add_vec('0, zero_o, "loaduse_one_cycle");
        t = '0; t.loade = 1; t.rde = 0; t.rs1d = 0; t.rs2d = 0;
        add_vec(t, zero_o, "loaduse_rd0");
        t = '0; t.loade = 1; t.rde = 7; t.rs1d = 7;
        add_vec(t, o(1,1,0,0,1,0, 2'b00, 2'b00, 0,0), "loaduse_rs1");
        t.loade = 0;
        add_vec(t, zero_o, "no_load_no_stall");
        t = '0; t.pcsrce = 1;
        add_vec(t, o(0,0,1,0,1,0, 2'b00, 2'b00, 0,0), "branch_flush");
        add_vec('0, zero_o, "branch_one_cycle");

        foreach (vecs[k]) step(vecs[k].i, vecs[k].e, vecs[k].name);

        // Held divide, then a back-to-back second divide; forwarding stays live.
        d = '0; d.mddive = 1; d.regwm = 1; d.rdm = 6; d.rs1e = 6;
        for (int rep = 0; rep < 2; rep++) begin
            step(d, o(1,1,0,1,0,1, 2'b10, 2'b00, 1,0), "div_start");
            for (int c = 1; c <= 4; c++) step(d, o(1,1,0,1,0,1, 2'b10, 2'b00, 0,1), "div_busy");
            step(d, o(0,0,0,0,0,0, 2'b10, 2'b00, 0,1), "div_done");
        end
        step('0, zero_o, "div_after_idle");

        // Load-use against D while the divide holds EX must not clear EX.
        d = '0; d.mddive = 1;
        step(d, o(1,1,0,1,0,1, 2'b00, 2'b00, 1,0), "div2_start");
        step(d, o(1,1,0,1,0,1, 2'b00, 2'b00, 0,1), "div2_busy");
        d.loade = 1; d.rde = 9; d.rs1d = 9;
        for (int c = 2; c <= 4; c++) step(d, o(1,1,0,1,0,1, 2'b00, 2'b00, 0,1), "div2_lu_masked");
        d = '0; d.mddive = 1; d.rs1d = 9;
        step(d, o(0,0,0,0,0,0, 2'b00, 2'b00, 0,1), "div2_done");
        d = '0; d.loade = 1; d.rde = 9; d.rs1d = 9;
        step(d, o(1,1,0,0,1,0, 2'b00, 2'b00, 0,0), "div2_lu_after");
        step('0, zero_o, "div2_clear");

        // Reset in BUSY with cnt == 2 abandons the divide.
        d = '0; d.mddive = 1; d.regww = 1; d.rdw = 2; d.rs2e = 2;
        step(d, o(1,1,0,1,0,1, 2'b00, 2'b01, 1,0), "rst_div_start");
        step(d, o(1,1,0,1,0,1, 2'b00, 2'b01, 0,1), "rst_div_cnt3");
        step(d, o(1,1,0,1,0,1, 2'b00, 2'b01, 0,1), "rst_div_cnt2");
        rst_n = 1'b0;
        #1;
        exp_q.push_back(zero_o); nm_q.push_back("rst_mid_div");
        check_pop();
        drive('0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step('0, zero_o, "post_rst_idle");
        t = '0; t.regww = 1; t.rdw = 2; t.rs2e = 2;
        step(t, o(0,0,0,0,0,0, 2'b00, 2'b01, 0,0), "post_rst_no_stall");
        step('0, zero_o, "post_rst_idle2");
        d = '0; d.mddive = 1;
        step(d, o(1,1,0,1,0,1, 2'b00, 2'b00, 1,0), "post_rst_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
